// File: rtl/constants_pkg.sv
// ---------------------------------------------------------------------------
// constants_pkg
// Shared constants and state encodings for the matrix datapath slice
// (matrix_feeder upstream of matrix_core).
//   DATA_WIDTH  - width of each W/X operand word
//   ACC_WIDTH   - matrix_core accumulator width
//   MAT_DIM     - square matrix dimension
//   W_DEPTH     - number of weight words (MAT_DIM*MAT_DIM)
//   X_DEPTH     - number of vector words (MAT_DIM)
//   TOTAL_DEPTH - feeder staging buffer depth (W_DEPTH + X_DEPTH)
// ---------------------------------------------------------------------------
package constants_pkg;

   localparam int DATA_WIDTH  = 8;
   localparam int MAT_DIM     = 4;
   localparam int ACC_WIDTH   = 2*DATA_WIDTH + 2;
   localparam int W_DEPTH     = MAT_DIM*MAT_DIM;
   localparam int X_DEPTH     = MAT_DIM;
   localparam int TOTAL_DEPTH = W_DEPTH + X_DEPTH;

   // matrix_core sequencing states
   typedef enum logic [1:0] {
      LOAD_W  = 2'd0,
      LOAD_X  = 2'd1,
      COMPUTE = 2'd2,
      FLUSH   = 2'd3
   } core_state_t;

   // matrix_feeder sequencing states
   typedef enum logic {
      FEED_IDLE   = 1'b0,
      FEED_STREAM = 1'b1
   } feed_state_t;

endpackage : constants_pkg

// File: rtl/feeder_buf.sv
// ---------------------------------------------------------------------------
// feeder_buf
// Staging register array for matrix_feeder: one synchronous write port and
// one asynchronous read port. Contents have no reset and survive a block
// reset. A write to the address currently being read is forwarded to the
// read port so the word being written is visible in the same cycle.
// Ports:
//   clk      in  clock, rising edge
//   wr_en    in  write strobe (caller guarantees wr_addr < TOTAL)
//   wr_addr  in  write index
//   wr_data  in  write data
//   rd_addr  in  read index
//   rd_data  out read data (combinational)
// ---------------------------------------------------------------------------
module feeder_buf #(
   parameter int DATA_WIDTH = constants_pkg::DATA_WIDTH,
   parameter int TOTAL      = constants_pkg::TOTAL_DEPTH,
   parameter int IDX_W      = $clog2(TOTAL)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL);

   logic [DATA_WIDTH-1:0] mem [TOTAL];

   // Storage is deliberately not reset so host data is retained across rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Write-then-read forwarding; in practice only address 0 is read while a
   // write can be in flight (start accepted in the same cycle as a write).
   always_comb begin
      rd_data = '0;
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_data = wr_data;
      end else if (rd_addr < TOTAL_IDX) begin
         rd_data = mem[rd_addr];
      end
   end

endmodule : feeder_buf

// File: rtl/matrix_feeder.sv
// ---------------------------------------------------------------------------
// matrix_feeder
// Host-loaded staging buffer (16 W words row-major, then 4 X words) that,
// on a start pulse, streams all words in index order over a valid/ready
// source interface into matrix_core's sink port.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-high reset
//   wr_en     in  host write strobe
//   wr_addr   in  buffer index (0..15 W, 16..19 X)
//   wr_data   in  host write data
//   start     in  single-cycle request to begin streaming
//   busy      out high from the cycle after an accepted start to last handshake
//   done      out one-cycle pulse after the final handshake
//   wr_err    out one-cycle pulse when a host write was dropped
//   src_vld   out stream valid
//   src_data  out stream data
//   src_last  out high with the final word
//   src_phase out 0 for W words, 1 for X words
//   src_rdy   in  stream ready
// ---------------------------------------------------------------------------
module matrix_feeder #(
   parameter int DATA_WIDTH = constants_pkg::DATA_WIDTH,
   parameter int W_DEPTH    = constants_pkg::W_DEPTH,
   parameter int X_DEPTH    = constants_pkg::X_DEPTH
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    wr_en,
   input  logic [$clog2(W_DEPTH+X_DEPTH)-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0]                   wr_data,
   input  logic                                    start,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    wr_err,
   output logic                                    src_vld,
   output logic [DATA_WIDTH-1:0]                   src_data,
   output logic                                    src_last,
   output logic                                    src_phase,
   input  logic                                    src_rdy
);

   import constants_pkg::*;

   localparam int TOTAL = W_DEPTH + X_DEPTH;
   localparam int IDX_W = $clog2(TOTAL);

   localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
   localparam logic [IDX_W-1:0] W_IDX     = IDX_W'(W_DEPTH);

   feed_state_t           state;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      next_idx;
   logic [IDX_W-1:0]      rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  buf_we;
   logic                  handshake;

   // Host writes only land while idle and in range; everything else is dropped.
   assign buf_we    = wr_en && (state == FEED_IDLE) && (wr_addr < TOTAL_IDX);
   assign handshake = src_vld && src_rdy;
   assign next_idx  = idx + IDX_W'(1);

   // Idle prefetches word 0 for the start; streaming prefetches the next word.
   // On the last word the lookahead is parked at 0 instead of running off the end.
   always_comb begin
      rd_addr = '0;
      if ((state == FEED_STREAM) && (idx != LAST_IDX)) begin
         rd_addr = next_idx;
      end
   end

   feeder_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .TOTAL      (TOTAL),
      .IDX_W      (IDX_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Feeder sequencer; every output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FEED_IDLE;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_err    <= 1'b0;
         src_vld   <= 1'b0;
         src_data  <= '0;
         src_last  <= 1'b0;
         src_phase <= 1'b0;
      end else begin
         done   <= 1'b0;
         wr_err <= 1'b0;
         case (state)
            FEED_IDLE: begin
               if (wr_en && (wr_addr >= TOTAL_IDX)) begin
                  wr_err <= 1'b1;
               end
               if (start) begin
                  state     <= FEED_STREAM;
                  busy      <= 1'b1;
                  src_vld   <= 1'b1;
                  src_data  <= rd_data;
                  idx       <= '0;
                  src_phase <= 1'b0;
                  src_last  <= 1'b0;
               end
            end
            FEED_STREAM: begin
               if (wr_en) begin
                  wr_err <= 1'b1;
               end
               if (handshake) begin
                  if (idx == LAST_IDX) begin
                     state    <= FEED_IDLE;
                     src_vld  <= 1'b0;
                     src_last <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     idx      <= '0;
                  end else begin
                     idx       <= next_idx;
                     src_data  <= rd_data;
                     src_phase <= (next_idx >= W_IDX);
                     src_last  <= (next_idx == LAST_IDX);
                  end
               end
            end
            default: begin
               state <= FEED_IDLE;
            end
         endcase
      end
   end

endmodule : matrix_feeder

// File: tb/tb_matrix_feeder.sv
// ---------------------------------------------------------------------------
// tb_matrix_feeder
// Directed self-checking bench for matrix_feeder. A reference copy of the
// buffer contents predicts every streamed word. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_matrix_feeder;

   localparam int DW    = 8;
   localparam int TOTAL = 20;
   localparam int IDX_W = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [IDX_W-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          start;
   logic          busy;
   logic          done;
   logic          wr_err;
   logic          src_vld;
   logic [DW-1:0] src_data;
   logic          src_last;
   logic          src_phase;
   logic          src_rdy;

   logic [DW-1:0] model [TOTAL];
   int total = 0;
   int bad   = 0;

   matrix_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .wr_err    (wr_err),
      .src_vld   (src_vld),
      .src_data  (src_data),
      .src_last  (src_last),
      .src_phase (src_phase),
      .src_rdy   (src_rdy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One idle-time host write; model follows the legal-write rule.
   task automatic applyStimulus(input logic [IDX_W-1:0] addr, input logic [DW-1:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      if (addr < TOTAL) model[addr] = data;
   endtask

   task automatic startStream();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("start_vld", {31'd0, src_vld}, 32'd1);
      checkOutput("start_busy", {31'd0, busy}, 32'd1);
   endtask

   // Consume the stream; stall=1 uses a ready pattern 1,0,0. stopAt>0 stops
   // after that many transfers without the end-of-stream checks.
   task automatic drainStream(input bit stall, input int stopAt);
      int got = 0;
      int cyc = 0;
      bit wasStalled = 1'b0;
      logic [DW-1:0] prevData = '0;
      while (got < TOTAL && cyc < 400) begin
         src_rdy = stall ? ((cyc % 3) == 0) : 1'b1;
         checkOutput("vld_held", {31'd0, src_vld}, 32'd1);
         checkOutput("no_early_done", {31'd0, done}, 32'd0);
         if (wasStalled) checkOutput("stall_stable", {24'd0, src_data}, {24'd0, prevData});
         if (src_rdy) begin
            checkOutput($sformatf("word%0d", got), {24'd0, src_data}, {24'd0, model[got]});
            checkOutput($sformatf("phase%0d", got), {31'd0, src_phase}, {31'd0, got >= 16});
            checkOutput($sformatf("last%0d", got), {31'd0, src_last}, {31'd0, got == TOTAL-1});
            got++;
         end
         wasStalled = !src_rdy;
         prevData   = src_data;
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (stopAt > 0 && got == stopAt) break;
      end
      src_rdy = 1'b0;
      if (stopAt <= 0) begin
         checkOutput("xfer_count", got, TOTAL);
         checkOutput("done_pulse", {31'd0, done}, 32'd1);
         checkOutput("end_vld", {31'd0, src_vld}, 32'd0);
         checkOutput("end_busy", {31'd0, busy}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         checkOutput("done_once", {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; src_rdy = 1'b0;
      #12;
      checkOutput("rst_vld", {31'd0, src_vld}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_data", {24'd0, src_data}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] load 1..20, full-rate stream");
      for (int i = 0; i < TOTAL; i++) applyStimulus(IDX_W'(i), DW'(i + 1));
      src_rdy = 1'b1;
      startStream();
      checkOutput("first_word", {24'd0, src_data}, 32'h01);
      drainStream(1'b0, 0);

      $display("[TB] stalled stream");
      startStream();
      drainStream(1'b1, 0);

      $display("[TB] writes and start while busy");
      startStream();
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 8'hFF; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      checkOutput("busy_wr_err", {31'd0, wr_err}, 32'd1);
      checkOutput("busy_data", {24'd0, src_data}, 32'h01);
      @(posedge clk);
      @(negedge clk);
      checkOutput("wr_err_pulse", {31'd0, wr_err}, 32'd0);
      drainStream(1'b0, 0);
      startStream();
      drainStream(1'b0, 0);

      $display("[TB] idle out-of-range write and write+start bypass");
      applyStimulus(5'd20, 8'h55);
      checkOutput("oor_wr_err", {31'd0, wr_err}, 32'd1);
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'hAA;
      model[0] = 8'hAA;
      startStream();
      wr_en = 1'b0;
      checkOutput("bypass_word", {24'd0, src_data}, 32'hAA);
      drainStream(1'b0, 0);

      $display("[TB] identity W, X=3,5,7,9 then X=1,1,1,1");
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) applyStimulus(IDX_W'(r*4 + c), (r == c) ? 8'd1 : 8'd0);
      applyStimulus(5'd16, 8'd3);
      applyStimulus(5'd17, 8'd5);
      applyStimulus(5'd18, 8'd7);
      applyStimulus(5'd19, 8'd9);
      startStream();
      drainStream(1'b0, 0);
      for (int i = 16; i < 20; i++) applyStimulus(IDX_W'(i), 8'd1);
      startStream();
      drainStream(1'b1, 0);

      $display("[TB] reset mid-stream");
      startStream();
      drainStream(1'b0, 7);
      checkOutput("pre_rst_word", {24'd0, src_data}, {24'd0, model[7]});
      rst = 1'b1;
      #1;
      checkOutput("midrst_vld", {31'd0, src_vld}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      #1;
      rst = 1'b0;
      @(negedge clk);
      startStream();
      checkOutput("restart_word0", {24'd0, src_data}, {24'd0, model[0]});
      drainStream(1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_matrix_feeder

// File: doc/matrix_feeder.md
Name: matrix_feeder

Overview:
Upstream stage of matrix_core. A host fills a 20-word staging buffer (16 W words in row-major order, then 4 X words) through a simple write port. On a start pulse, the block streams all 20 words in index order over a valid/ready source interface into matrix_core's sink port. It reports busy and done, and flags illegal host accesses.

Parameters:
DATA_WIDTH, DATA_WIDTH from constants_pkg (8), width of each W/X word
W_DEPTH, W_DEPTH from constants_pkg (16), number of weight words (MAT_DIM*MAT_DIM)
X_DEPTH, X_DEPTH from constants_pkg (4), number of vector words
TOTAL, W_DEPTH+X_DEPTH (20), staging buffer depth (derived localparam)
IDX_W, $clog2(TOTAL) (5), width of address and index (derived localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  host write strobe
wr_addr  in  IDX_W  buffer index; 0..15 = W, 16..19 = X
wr_data  in  DATA_WIDTH  host write data
start  in  1  single-cycle request to begin streaming
busy  out  1  high from the cycle after an accepted start until the final handshake
done  out  1  one-cycle pulse, registered, in the cycle after the last handshake
wr_err  out  1  one-cycle pulse: a host write was dropped
src_vld  out  1  stream valid (to matrix_core snk_vld)
src_data  out  DATA_WIDTH  stream data (to matrix_core snk_data)
src_last  out  1  high with the final word (index TOTAL-1)
src_phase  out  1  0 while sending a W word, 1 while sending an X word
src_rdy  in  1  stream ready (from matrix_core snk_rdy)

Behaviour:
- Reset (async assert): state=IDLE, idx=0, busy=0, done=0, wr_err=0, src_vld=0, src_data=0, src_last=0, src_phase=0. Buffer contents are not cleared; they are retained across reset.
- All outputs are registered. A transfer occurs on a rising edge with src_vld && src_rdy.
- States: IDLE, STREAM.
- IDLE:
  - wr_en with wr_addr < TOTAL writes buf[wr_addr].
  - wr_addr >= TOTAL: write dropped, wr_err pulses next cycle.
  - start accepted: next cycle state=STREAM, busy=1, src_vld=1, src_data=buf[0], idx=0, src_phase=0, src_last=0.
  - Latency from start to first valid word is 1 cycle.
- Same-cycle wr_en and start in IDLE: the write commits, and the start is accepted. If wr_addr==0, the new wr_data is forwarded to src_data (write-then-read).
- STREAM:
  - src_vld held high; src_data/src_last/src_phase held stable until a handshake. No retraction.
  - On handshake with idx < TOTAL-1: idx<=idx+1, src_data<=buf[idx+1], src_phase<=(idx+1 >= W_DEPTH), src_last<=(idx+1 == TOTAL-1). Back-to-back handshakes give 1 word per cycle.
  - On handshake with idx == TOTAL-1: src_vld<=0, src_last<=0, busy<=0, done<=1 for one cycle, idx<=0, state=IDLE.
- While busy:
  - start is ignored, with no error.
  - Every wr_en is dropped (buffer is unchanged) and wr_err pulses.
- src_rdy low for any number of cycles stalls the stream indefinitely; there is no timeout.
- A start in the same cycle as the done pulse: accepted, because state is already IDLE.
- Reset mid-stream: src_vld drops immediately (async). The next start streams from index 0. The downstream consumer must also be reset, since matrix_core counts are not re-synchronised by this block.
- Index counter saturates at TOTAL-1 by construction; it never wraps.

Decomposition:
- constants_pkg holds DATA_WIDTH, ACC_WIDTH, MAT_DIM, W_DEPTH, X_DEPTH, and the new TOTAL_DEPTH.
- constants_pkg also holds a feeder state enum typedef (FEED_IDLE, FEED_STREAM) beside the existing LOAD_W/LOAD_X/COMPUTE/FLUSH encodings.
- One sub-module is natural: feeder_buf, a TOTAL x DATA_WIDTH register array with 1 write port, 1 async read port and the addr-0 bypass.

Test Plan:
- Write buf[i]=i+1 (i=0..19), start, src_rdy=1 -> src_vld rises the cycle after start. Words 0x01..0x14 appear on 20 consecutive cycles. src_phase=1 on words 0x11..0x14 only; src_last on 0x14 only; done pulses once.
- Same load, src_rdy toggling 1,0,0,1,... -> each word is held stable during stalls, there are no duplicates or skips, and exactly 20 transfers occur.
- Back-to-back with matrix_core: W=identity (1 on diagonal), X=3,5,7,9 -> matrix_core emits 3,5,7,9. A second start after done with X=1,1,1,1 -> it emits 1,1,1,1.
- While busy: wr_en addr 2 data 0xFF, plus a start -> wr_err pulses, the stream is unaffected, and buf[2] still reads 0x03 on the next run.
- IDLE: wr_en addr 20 -> wr_err pulse, no buffer change. wr_en addr 0 data 0xAA together with start -> the first streamed word is 0xAA.
- Assert rst at word 7 -> src_vld=0 and busy=0 at once. After release, start -> the stream restarts at word 0 with the retained buffer values.
